mul_div_unit: RTL

//  Iterative multiply/divide unit with architectural HI/LO registers; sits beside the EX-stage ALU.

---
 rtl/mul_div_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One iteration per cycle for WIDTH cycles, then a single sign-fixup cycle.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_up;
    logic [WIDTH-1:0] r_low;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_a;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;

    logic             w_issue;
    logic             w_iter;
    logic             w_mt;
    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] v,
                                               input logic is_signed);
        logic [WIDTH-1:0] m;
        m = v;
        if (is_signed && v < 0) m = -m;
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // A cancel in the same cycle as start drops the issue, including MTHI/MTLO.
    assign w_issue  = (r_state == S_IDLE) && start && !cancel;
    assign w_iter   = w_issue && !op[2];
    assign w_mt     = w_issue && (op[2:1] == 2'b10);
    assign w_signed = !op[2] && !op[0];
    assign w_abs_a  = f_mag($signed(A), w_signed);
    assign w_abs_b  = f_mag($signed(B), w_signed);
    assign busy     = (r_state != S_IDLE);

    assign w_mul_sum   = {1'b0, r_up} + (r_low[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = {r_up, r_low[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;

    always_comb begin
        w_prod   = f_neg_2w({r_up, r_low}, r_neg_q);
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_hi = r_dz ? r_a : f_neg_w(r_up, r_neg_r);
            w_fix_lo = r_dz ? '1  : f_neg_w(r_low, r_neg_q);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_iter) w_next = S_RUN;
            S_RUN:   if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (cancel && r_state != S_IDLE) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_iter) begin
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_neg_q  <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_r  <= w_signed && A[WIDTH-1];
                        r_dz     <= (B == '0);
                        r_a      <= A;
                        r_up     <= '0;
                        // Multiply consumes B from r_low; divide shifts A out of r_low.
                        r_low    <= op[1] ? w_abs_a : w_abs_b;
                        r_opnd   <= op[1] ? w_abs_b : w_abs_a;
                    end
                    if (w_mt && !op[0]) hi <= A;
                    if (w_mt &&  op[0]) lo <= A;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_is_div) begin
                        r_up  <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                        r_low <= {r_low[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_up  <= w_mul_sum[WIDTH:1];
                        r_low <= {w_mul_sum[0], r_low[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        hi <= w_fix_hi;
                        lo <= w_fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
